// File: rtl/animated_sprite.sv
// animated_sprite: per-pixel sprite window locator.
// Compares the beam position against a sprite's top-left corner and emits
// sprite-local column/row coordinates plus an in-window flag, all registered
// with one clock of latency. Coordinates wrap modulo 1024 on both axes.
// Optional feature macro: SPRITE_MIRROR_EN (adds hflip/vflip inputs that
// mirror the local coordinates inside the window).
module animated_sprite #(
   parameter int SPR_W = 16,
   parameter int SPR_H = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] shpos,
   input  logic [9:0] svpos,
   input  logic [9:0] xpos,
   input  logic [9:0] ypos,
`ifdef SPRITE_MIRROR_EN
   input  logic       hflip,
   input  logic       vflip,
`endif
   output logic [3:0] xout,
   output logic [3:0] yout,
   output logic       active
);

   // Window extents as 10-bit values so the comparison stays width-matched.
   localparam logic [9:0] LP_W     = 10'(SPR_W);
   localparam logic [9:0] LP_H     = 10'(SPR_H);
   // Last valid local column/row, used when mirroring.
   localparam logic [3:0] LP_W_M1  = 4'(SPR_W - 1);
   localparam logic [3:0] LP_H_M1  = 4'(SPR_H - 1);

   logic [9:0] w_dx;
   logic [9:0] w_dy;
   logic       w_inside;
   logic [3:0] w_xout_next;
   logic [3:0] w_yout_next;

   logic [3:0] r_xout;
   logic [3:0] r_yout;
   logic       r_active;

   // Wrap-around offsets: a negative difference becomes a large value and
   // naturally falls outside the window, so one unsigned compare per axis
   // handles sprites straddling the 1023->0 seam.
   assign w_dx     = shpos - xpos;
   assign w_dy     = svpos - ypos;
   assign w_inside = (w_dx < LP_W) && (w_dy < LP_H);

   // Next-cycle local coordinates; forced to 0 outside so downstream ROMs
   // address the transparent border.
   always_comb begin
      w_xout_next = 4'd0;
      w_yout_next = 4'd0;
      if (w_inside) begin
`ifdef SPRITE_MIRROR_EN
         w_xout_next = hflip ? (LP_W_M1 - w_dx[3:0]) : w_dx[3:0];
         w_yout_next = vflip ? (LP_H_M1 - w_dy[3:0]) : w_dy[3:0];
`else
         w_xout_next = w_dx[3:0];
         w_yout_next = w_dy[3:0];
`endif
      end
   end

   // Output registers: single stage of latency, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_xout   <= 4'd0;
         r_yout   <= 4'd0;
         r_active <= 1'b0;
      end else begin
         r_xout   <= w_xout_next;
         r_yout   <= w_yout_next;
         r_active <= w_inside;
      end
   end

   assign xout   = r_xout;
   assign yout   = r_yout;
   assign active = r_active;

`ifndef SPRITE_MIRROR_EN
   // Mirror constants exist only for the flip path.
   logic w_unused_consts;
   assign w_unused_consts = ^{LP_W_M1, LP_H_M1};
`endif

endmodule

// File: tb/tb_animated_sprite.sv
// Testbench for animated_sprite: directed steps from the test plan followed
// by randomized beam/sprite positions, checked against a plain-arithmetic
// reference model. Two instances: default 16x16 and an 8x8 sprite.
module tb_animated_sprite;

   logic       clk;
   logic       reset;
   logic [9:0] shpos;
   logic [9:0] svpos;
   logic [9:0] xpos;
   logic [9:0] ypos;
   logic       hflip;
   logic       vflip;
   logic [3:0] xout16, yout16, xout8, yout8;
   logic       active16, active8;

   int n_compared   = 0;
   int n_mismatched = 0;

   animated_sprite #(.SPR_W(16), .SPR_H(16)) dut16 (
      .clk(clk), .reset(reset),
      .shpos(shpos), .svpos(svpos), .xpos(xpos), .ypos(ypos),
`ifdef SPRITE_MIRROR_EN
      .hflip(hflip), .vflip(vflip),
`endif
      .xout(xout16), .yout(yout16), .active(active16)
   );

   animated_sprite #(.SPR_W(8), .SPR_H(8)) dut8 (
      .clk(clk), .reset(reset),
      .shpos(shpos), .svpos(svpos), .xpos(xpos), .ypos(ypos),
`ifdef SPRITE_MIRROR_EN
      .hflip(hflip), .vflip(vflip),
`endif
      .xout(xout8), .yout(yout8), .active(active8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: expected {active, xout, yout} for given inputs.
   function automatic void model(input int w, input int h, input bit rst,
                                 input int sh, input int sv, input int xp, input int yp,
                                 input bit hf, input bit vf,
                                 output int ea, output int ex, output int ey);
      int dx, dy;
      dx = (sh - xp + 1024) % 1024;
      dy = (sv - yp + 1024) % 1024;
      ea = 0; ex = 0; ey = 0;
      if (!rst && dx < w && dy < h) begin
         ea = 1;
         ex = dx;
         ey = dy;
`ifdef SPRITE_MIRROR_EN
         if (hf) ex = w - 1 - dx;
         if (vf) ey = h - 1 - dy;
`endif
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one input set, clock it in, then check both instances.
   task automatic step(input string tag, input bit rst, input int sh, input int sv,
                       input int xp, input int yp, input bit hf, input bit vf);
      int ea, ex, ey;
      reset = rst;
      shpos = 10'(sh); svpos = 10'(sv); xpos = 10'(xp); ypos = 10'(yp);
      hflip = hf; vflip = vf;
      @(posedge clk);
      #1;
      model(16, 16, rst, sh, sv, xp, yp, hf, vf, ea, ex, ey);
      chk({tag, "/a16"}, 32'(active16), 32'(ea));
      chk({tag, "/x16"}, 32'(xout16),  32'(ex));
      chk({tag, "/y16"}, 32'(yout16),  32'(ey));
      model(8, 8, rst, sh, sv, xp, yp, hf, vf, ea, ex, ey);
      chk({tag, "/a8"}, 32'(active8), 32'(ea));
      chk({tag, "/x8"}, 32'(xout8),  32'(ex));
      chk({tag, "/y8"}, 32'(yout8),  32'(ey));
      $display("step %s rst=%0d sh=%0d sv=%0d xp=%0d yp=%0d hf=%0d vf=%0d -> a16=%0d x16=%0d y16=%0d a8=%0d x8=%0d y8=%0d",
               tag, rst, sh, sv, xp, yp, hf, vf, active16, xout16, yout16, active8, xout8, yout8);
   endtask

   initial begin
      reset = 1'b1; shpos = '0; svpos = '0; xpos = '0; ypos = '0;
      hflip = 1'b0; vflip = 1'b0;
      @(negedge clk);

      // Reset, then release on a beam exactly on the corner.
      step("rst",     1'b1, 20, 20, 20, 20, 1'b0, 1'b0);
      // Explicit constant checks from the plan.
      chk("rst_a_const", 32'(active16), 32'd0);
      step("rel",     1'b0, 20, 20, 20, 20, 1'b0, 1'b0);
      chk("rel_a_const", 32'(active16), 32'd1);

      // Horizontal sweep across the window.
      for (int s = 99; s <= 116; s++) step("hsweep", 1'b0, s, 57, 100, 50, 1'b0, 1'b0);
      // Confirm one sweep value in constants: shpos=115 gave xout=15.
      step("hlast", 1'b0, 115, 57, 100, 50, 1'b0, 1'b0);
      chk("hlast_x_const", 32'(xout16), 32'd15);

      // Vertical edges.
      step("v49", 1'b0, 105, 49, 100, 50, 1'b0, 1'b0);
      step("v50", 1'b0, 105, 50, 100, 50, 1'b0, 1'b0);
      step("v65", 1'b0, 105, 65, 100, 50, 1'b0, 1'b0);
      chk("v65_y_const", 32'(yout16), 32'd15);
      step("v66", 1'b0, 105, 66, 100, 50, 1'b0, 1'b0);

      // Wrap-around on both axes.
      step("wrap_in",  1'b0, 2, 3, 1012, 1012, 1'b0, 1'b0);
      chk("wrap_x_const", 32'(xout16), 32'd14);
      chk("wrap_y_const", 32'(yout16), 32'd15);
      step("wrap_0",   1'b0, 0, 0, 1012, 1012, 1'b0, 1'b0);
      step("wrap_out", 1'b0, 4, 3, 1012, 1012, 1'b0, 1'b0);

      // 8x8 boundary.
      step("b8_in",  1'b0, 7, 7, 0, 0, 1'b0, 1'b0);
      chk("b8_x_const", 32'(xout8), 32'd7);
      step("b8_out", 1'b0, 8, 7, 0, 0, 1'b0, 1'b0);
      chk("b8_a_const", 32'(active8), 32'd0);

      // Mirror cases (identity when the feature is absent).
      step("mir11", 1'b0, 3, 5, 0, 0, 1'b1, 1'b1);
      step("mir00", 1'b0, 3, 5, 0, 0, 1'b0, 1'b0);

      // Mid-stream reset.
      step("mrst", 1'b1, 101, 51, 100, 50, 1'b0, 1'b0);
      step("mrel", 1'b0, 101, 51, 100, 50, 1'b0, 1'b0);

      // Randomized: positions biased near the sprite so the window is hit often.
      for (int i = 0; i < 300; i++) begin
         int xp, yp, sh, sv;
         bit rst;
         xp  = int'($urandom_range(0, 1023));
         yp  = int'($urandom_range(0, 1023));
         sh  = (xp + int'($urandom_range(0, 40)) - 12 + 1024) % 1024;
         sv  = (yp + int'($urandom_range(0, 40)) - 12 + 1024) % 1024;
         rst = ($urandom_range(0, 19) == 0);
         step("rand", rst, sh, sv, xp, yp, 1'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   // Safety net in case the clock stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

endmodule
